// File: rtl/op_unit_pipe.sv
// Two-stage pipelined operator unit with valid/ready on both sides; S1 holds operands, S2 holds the result.
// Build option ILLEGAL_OP_TRAP_EN adds an illegal-opcode err output with a sticky err_seen latch.
module op_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             err
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SHR = OPW'(1);
    localparam logic [OPW-1:0] OP_GT  = OPW'(2);
    localparam logic [OPW-1:0] OP_EQ  = OPW'(3);
    localparam logic [OPW-1:0] OP_AND = OPW'(4);
    localparam logic [OPW-1:0] OP_ROR = OPW'(5);
    localparam logic [OPW-1:0] OP_LOR = OPW'(6);
    localparam logic [OPW-1:0] OP_CAT = OPW'(7);
    localparam logic [OPW-1:0] OP_MAX = OPW'(8);
    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);

    logic             s1_valid_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_q;

    logic             adv2;
    logic             in_fire;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result_d;
    logic             flag_d;

    // S2 may drain and S1 refill in the same cycle, so in_ready looks through to out_ready.
    assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | adv2;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        sum      = {1'b0, b_q} + {1'b0, c_q};
        result_d = '0;
        flag_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                result_d = sum[WIDTH-1:0];
                flag_d   = sum[WIDTH];
            end
            OP_SHR: result_d = ({1'b0, c_q} >= SHIFT_LIM) ? '0 : (b_q >> c_q);
            OP_GT:  result_d = WIDTH'(a_q > b_q);
            OP_EQ:  result_d = WIDTH'(a_q == d_q);
            OP_AND: result_d = b_q & c_q;
            OP_ROR: result_d = WIDTH'(|b_q);
            OP_LOR: result_d = WIDTH'((a_q > b_q) || (a_q > d_q));
            OP_CAT: result_d = {c_q[WIDTH/2-1:0], d_q[WIDTH-1:WIDTH/2]};
            OP_MAX: result_d = (a_q > b_q) ? a_q : b_q;
            default: begin
                result_d = '0;
                flag_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            c_q  <= c;
            d_q  <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
            end else if (adv2) begin
                s1_valid_q <= 1'b0;
            end
            if (adv2) begin
                out_valid_q <= 1'b1;
                result_q    <= result_d;
                flag_q      <= flag_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag      = flag_q;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal;
    logic err_q;
    logic err_seen_q;

    assign illegal = (op_q > OP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
        end else if (adv2) begin
            err_q <= illegal;
            if (illegal) begin
                err_seen_q <= 1'b1;
            end
        end
    end

    assign err = err_q | err_seen_q;
`else
    assign err = 1'b0;
`endif

endmodule
